// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives program memory, buffers fetched words in a
// 2-entry FIFO toward decode, and handles branch redirects and halt detection.
module instr_fetch_unit #(
  parameter int unsigned     AW        = 5,
  parameter int unsigned     DW        = 32,
  parameter logic [AW-1:0]   RESET_PC  = '0,
  parameter logic [DW-1:0]   HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_en,
  output logic [AW-1:0] pmem_adres,
  input  logic [DW-1:0] pmem_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] instr_out,
  output logic [AW-1:0] instr_pc,
  output logic          halted
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]    r_state;
  logic [AW-1:0] r_fetch_pc;
  logic [AW-1:0] r_pc_buf   [2];
  logic [DW-1:0] r_word_buf [2];
  logic          r_head;
  logic [1:0]    r_count;

  logic w_pop;
  logic w_push;
  logic w_tail;
  logic w_halt_hit;

  assign w_pop      = (r_count != 2'd0) && instr_ready;
  assign w_push     = (r_state == S_RUN) && fetch_en && !redirect_valid &&
                      ((r_count != 2'd2) || w_pop);
  // With two entries the tail is the head slot when empty or full, else the other one
  assign w_tail     = r_head ^ r_count[0];
  assign w_halt_hit = w_push && (pmem_data == HALT_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_head     <= 1'b0;
      r_count    <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_pc_buf[i]   <= '0;
        r_word_buf[i] <= '0;
      end
    end else if (redirect_valid) begin
      r_head     <= 1'b0;
      r_count    <= 2'd0;
      r_fetch_pc <= redirect_pc;
      r_state    <= fetch_en ? S_RUN : S_IDLE;
    end else begin
      if (w_push) begin
        r_pc_buf[w_tail]   <= r_fetch_pc;
        r_word_buf[w_tail] <= pmem_data;
        if (!w_halt_hit)
          r_fetch_pc <= r_fetch_pc + AW'(1);
      end
      if (w_pop)
        r_head <= ~r_head;
      if (w_push && !w_pop)
        r_count <= r_count + 2'd1;
      else if (!w_push && w_pop)
        r_count <= r_count - 2'd1;

      case (r_state)
        S_IDLE:  if (fetch_en) r_state <= S_RUN;
        S_RUN: begin
          if (w_halt_hit)     r_state <= S_HALT;
          else if (!fetch_en) r_state <= S_IDLE;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pmem_adres  = r_fetch_pc;
  assign instr_valid = (r_count != 2'd0);
  assign instr_out   = instr_valid ? r_word_buf[r_head] : '0;
  assign instr_pc    = instr_valid ? r_pc_buf[r_head]   : '0;
  assign halted      = (r_state == S_HALT);

endmodule
